// File: rtl/fejkon_pcie_csr.sv
// CSR responder for the fejkon mem_access request/response stream.
// Define FEJKON_CSR_STATS_EN to build the write/read counters at 0x08/0x0C.
module fejkon_pcie_csr #(
    parameter logic [31:0] DEVICE_ID = 32'h02010de5,
    parameter logic [31:0] VERSION   = 32'hdeadbeef
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] mem_access_req_data,
    input  logic         mem_access_req_valid,
    output logic         mem_access_req_ready,
    output logic [127:0] mem_access_resp_data,
    output logic         mem_access_resp_valid,
    input  logic         mem_access_resp_ready,
    output logic [7:0]   ctrl_out
);

    logic         resp_valid_q, resp_valid_d;
    logic [127:0] resp_data_q, resp_data_d;
    logic [31:0]  scratch_q, scratch_d;
    logic [7:0]   ctrl_q, ctrl_d;
`ifdef FEJKON_CSR_STATS_EN
    logic [31:0]  wr_cnt_q, wr_cnt_d;
    logic [31:0]  rd_cnt_q, rd_cnt_d;
`endif

    logic         req_wr;
    logic [31:0]  req_wdata;
    logic [23:0]  req_tag;
    logic [31:0]  req_addr;
    logic [31:0]  rdata;
    logic         accept;
    logic         unused_req_bits;

    assign req_wr    = mem_access_req_data[0];
    assign req_wdata = mem_access_req_data[32:1];
    assign req_tag   = mem_access_req_data[24:1];
    assign req_addr  = {mem_access_req_data[62:33], 2'b00};
    assign unused_req_bits = ^mem_access_req_data[127:63];

    // Ready depends only on the buffer state and downstream ready, never on req_valid.
    assign mem_access_req_ready = !resp_valid_q || mem_access_resp_ready;
    assign accept = mem_access_req_valid && mem_access_req_ready;

    always_comb begin
        rdata = 32'hffffffff;
        case (req_addr)
            32'h00: rdata = DEVICE_ID;
            32'h04: rdata = VERSION;
`ifdef FEJKON_CSR_STATS_EN
            32'h08: rdata = wr_cnt_q;
            32'h0c: rdata = rd_cnt_q;
`endif
            32'h80: rdata = scratch_q;
            32'h84: rdata = {24'h0, ctrl_q};
            default: rdata = 32'hffffffff;
        endcase
    end

    always_comb begin
        scratch_d   = scratch_q;
        ctrl_d      = ctrl_q;
        resp_data_d = resp_data_q;
`ifdef FEJKON_CSR_STATS_EN
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
`endif
        if (accept && !req_wr)
            resp_valid_d = 1'b1;
        else if (mem_access_resp_ready)
            resp_valid_d = 1'b0;
        else
            resp_valid_d = resp_valid_q;

        if (accept) begin
            if (req_wr) begin
                if (req_addr == 32'h80) scratch_d = req_wdata;
                if (req_addr == 32'h84) ctrl_d    = req_wdata[7:0];
`ifdef FEJKON_CSR_STATS_EN
                wr_cnt_d = wr_cnt_q + 32'd1;
`endif
            end else begin
                resp_data_d = {64'h0, rdata, 3'b000, req_addr[6:2], req_tag};
`ifdef FEJKON_CSR_STATS_EN
                rd_cnt_d = rd_cnt_q + 32'd1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            scratch_q    <= 32'hffffffff;
            ctrl_q       <= 8'h00;
`ifdef FEJKON_CSR_STATS_EN
            wr_cnt_q     <= 32'h0;
            rd_cnt_q     <= 32'h0;
`endif
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            scratch_q    <= scratch_d;
            ctrl_q       <= ctrl_d;
`ifdef FEJKON_CSR_STATS_EN
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
`endif
        end
    end

    assign mem_access_resp_valid = resp_valid_q;
    assign mem_access_resp_data  = resp_data_q;
    assign ctrl_out              = ctrl_q;

endmodule

// File: tb/tb_fejkon_pcie_csr.sv
// Bench for fejkon_pcie_csr: directed vector table, hand-written stall/reset
// sequences and random traffic checked against a register-map model.
module tb_fejkon_pcie_csr;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] req_data = '0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [127:0] resp_data;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [7:0]   ctrl_out;

    always #5 clk = ~clk;

    fejkon_pcie_csr dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .mem_access_req_data   (req_data),
        .mem_access_req_valid  (req_valid),
        .mem_access_req_ready  (req_ready),
        .mem_access_resp_data  (resp_data),
        .mem_access_resp_valid (resp_valid),
        .mem_access_resp_ready (resp_ready),
        .ctrl_out              (ctrl_out)
    );

`ifdef FEJKON_CSR_STATS_EN
    localparam bit          STATS  = 1'b1;
    localparam logic [31:0] EXP_WC = 32'd3;
    localparam logic [31:0] EXP_RC = 32'd3;
`else
    localparam bit          STATS  = 1'b0;
    localparam logic [31:0] EXP_WC = 32'hffffffff;
    localparam logic [31:0] EXP_RC = 32'hffffffff;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents plus the completions still owed.
    logic [31:0]  m_scratch;
    logic [7:0]   m_ctrl;
    logic [31:0]  m_wc, m_rc;
    logic [127:0] m_q[$];

    bit          cur_wr;
    logic [31:0] cur_addr, cur_wdata;
    logic [23:0] cur_tag;

    typedef struct {
        bit          rst;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [23:0] tag;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_ctrl;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == 32'h00) return 32'h02010de5;
        if (a == 32'h04) return 32'hdeadbeef;
        if (a == 32'h08) return STATS ? m_wc : 32'hffffffff;
        if (a == 32'h0c) return STATS ? m_rc : 32'hffffffff;
        if (a == 32'h80) return m_scratch;
        if (a == 32'h84) return {24'h0, m_ctrl};
        return 32'hffffffff;
    endfunction

    task automatic set_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [23:0] tag, input logic [31:0] junk);
        logic [127:0] d;
        cur_wr = wr; cur_addr = {a[31:2], 2'b00}; cur_wdata = wd; cur_tag = tag;
        d = '0;
        d[0] = wr;
        if (wr) d[32:1] = wd;
        else    d[24:1] = tag;
        d[62:33] = a[31:2];
        d[94:63] = junk;
        req_data = d;
    endtask

    task automatic model_reset();
        m_scratch = 32'hffffffff;
        m_ctrl = 8'h00;
        m_wc = 0;
        m_rc = 0;
        m_q.delete();
    endtask

    // One clock: check outputs mid-cycle, then advance the model past the edge.
    task automatic tick();
        bit acc, hand;
        logic [127:0] comp;
        @(negedge clk);
        check("resp_valid", resp_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("resp_data", resp_data, m_q[0]);
        check("req_ready", req_ready, (m_q.size() == 0) || resp_ready);
        check("ctrl_out", ctrl_out, m_ctrl);
        hand = (m_q.size() != 0) && resp_ready;
        acc  = req_valid && ((m_q.size() == 0) || resp_ready);
        comp = {64'h0, model_read(cur_addr), 3'b000, cur_addr[6:2], cur_tag};
        @(posedge clk);
        #1;
        if (hand) void'(m_q.pop_front());
        if (acc) begin
            if (cur_wr) begin
                if (cur_addr == 32'h80) m_scratch = cur_wdata;
                if (cur_addr == 32'h84) m_ctrl = cur_wdata[7:0];
                m_wc = m_wc + 1;
            end else begin
                m_q.push_back(comp);
                m_rc = m_rc + 1;
            end
        end
    endtask

    // Called mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst resp_valid", resp_valid, 1'b0);
        check("rst req_ready", req_ready, 1'b1);
        check("rst resp_data", resp_data, 128'h0);
        check("rst ctrl_out", ctrl_out, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{1, 0, 32'h000, 32'h0,        24'h010203, 32'h02010de5, 8'h00};
        tbl[1]  = '{0, 0, 32'h004, 32'h0,        24'h010203, 32'hdeadbeef, 8'h00};
        tbl[2]  = '{0, 1, 32'h080, 32'h12345678, 24'h0,      32'h0,        8'h00};
        tbl[3]  = '{0, 0, 32'h080, 32'h0,        24'h000042, 32'h12345678, 8'h00};
        tbl[4]  = '{0, 1, 32'h084, 32'h000001ff, 24'h0,      32'h0,        8'hff};
        tbl[5]  = '{0, 0, 32'h084, 32'h0,        24'h000043, 32'h000000ff, 8'hff};
        tbl[6]  = '{0, 0, 32'h100, 32'h0,        24'h000044, 32'hffffffff, 8'hff};
        tbl[7]  = '{0, 1, 32'h000, 32'h0,        24'h0,      32'h0,        8'hff};
        tbl[8]  = '{0, 0, 32'h000, 32'h0,        24'h000045, 32'h02010de5, 8'hff};
        tbl[9]  = '{1, 1, 32'h080, 32'h1,        24'h0,      32'h0,        8'h00};
        tbl[10] = '{0, 1, 32'h084, 32'h3c,       24'h0,      32'h0,        8'h3c};
        tbl[11] = '{0, 1, 32'h200, 32'h5,        24'h0,      32'h0,        8'h3c};
        tbl[12] = '{0, 0, 32'h000, 32'h0,        24'habcdef, 32'h02010de5, 8'h3c};
        tbl[13] = '{0, 0, 32'h004, 32'h0,        24'habcdef, 32'hdeadbeef, 8'h3c};
        tbl[14] = '{0, 0, 32'h008, 32'h0,        24'habcdef, EXP_WC,       8'h3c};
        tbl[15] = '{0, 0, 32'h00c, 32'h0,        24'habcdef, EXP_RC,       8'h3c};

        model_reset();
        set_req(0, 0, 0, 0, 0);
        #1;

        // Directed vectors: one request, inspect completion, drain.
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst) do_reset();
            set_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].tag, 32'h0);
            req_valid = 1'b1;
            resp_ready = 1'b1;
            tick();
            req_valid = 1'b0;
            if (!tbl[i].wr) begin
                check($sformatf("vec%0d valid", i), resp_valid, 1'b1);
                check($sformatf("vec%0d rdata", i), resp_data[63:32], tbl[i].exp_rdata);
                check($sformatf("vec%0d addr", i), resp_data[28:24], tbl[i].addr[6:2]);
                check($sformatf("vec%0d tag", i), resp_data[23:0], tbl[i].tag);
            end else begin
                check($sformatf("vec%0d no_cpl", i), resp_valid, 1'b0);
            end
            check($sformatf("vec%0d ctrl", i), ctrl_out, tbl[i].exp_ctrl);
            tick();
        end

        // Stall: first read held in the buffer, second read waits for 5 cycles.
        resp_ready = 1'b0;
        set_req(0, 32'h00, 0, 24'h000001, 0);
        req_valid = 1'b1;
        tick();
        set_req(0, 32'h04, 0, 24'h000002, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall req_ready", req_ready, 1'b0);
        end
        check("stall depth", m_q.size(), 1);
        resp_ready = 1'b1;
        tick();
        check("handoff reload", resp_valid, 1'b1);
        set_req(0, 32'h80, 0, 24'h000003, 0);
        tick();
        set_req(0, 32'h84, 0, 24'h000004, 0);
        tick();
        req_valid = 1'b0;
        check("b2b last", resp_data[23:0], 24'h000004);
        tick();
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 7))
                0: a = 32'h00;  1: a = 32'h04;  2: a = 32'h08;  3: a = 32'h0c;
                4: a = 32'h80;  5: a = 32'h84;  6: a = 32'h100;
                default: a = $urandom & 32'hfffffffc;
            endcase
            set_req($urandom_range(0, 2) == 0, a, $urandom, 24'($urandom), $urandom);
            req_valid  = $urandom_range(0, 3) != 0;
            resp_ready = $urandom_range(0, 9) < 7;
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        tick();

        // Reset while a completion is stalled.
        set_req(1, 32'h80, 32'haaaa5555, 0, 0);
        req_valid = 1'b1;
        tick();
        set_req(1, 32'h84, 32'h5a, 0, 0);
        tick();
        resp_ready = 1'b0;
        set_req(0, 32'h80, 0, 24'h000777, 0);
        tick();
        req_valid = 1'b0;
        tick();
        check("pre-reset pending", resp_valid, 1'b1);
        do_reset();
        resp_ready = 1'b1;
        set_req(0, 32'h80, 0, 24'h000888, 0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("post-reset scratch", resp_data[63:32], 32'hffffffff);
        check("post-reset ctrl", ctrl_out, 8'h00);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fejkon_pcie_csr.md
# fejkon_pcie_csr

Register-file responder on the `mem_access` request/response stream emitted by `fejkon_pcie_data`. It decodes 128-bit memory-access requests (BAR reads/writes) and answers reads with completion payloads carrying requester/tag and lower address. It owns the device ID, version, statistics counters, scratch and control registers, and applies response backpressure to the request stream.

## Interface
- `DEVICE_ID`, 32'h02010de5, value returned at 0x00
- `VERSION`, 32'hdeadbeef, value returned at 0x04
- `clk`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `mem_access_req_data`  in  128  request: [0] write flag, [32:1] write data, [24:1] requester+tag (reads), [62:33] address[31:2]
- `mem_access_req_valid`  in  1  request valid
- `mem_access_req_ready`  out  1  request accepted when valid && ready
- `mem_access_resp_data`  out  128  completion: [23:0] requester+tag, [28:24] address[6:2], [63:32] read data, other bits 0
- `mem_access_resp_valid`  out  1  completion valid
- `mem_access_resp_ready`  in  1  downstream accepts completion
- `ctrl_out`  out  8  control register contents

## Operation
- Address = {req_data[62:33], 2'b00}; bits [94:63] ignored.
- Register map (32-bit, dword aligned):
  - 0x00 RO `DEVICE_ID`; 0x04 RO `VERSION`
  - 0x08 RO write counter: accepted writes to any address
  - 0x0C RO read counter: accepted reads to any address
  - 0x80 RW scratch, reset 32'hffffffff
  - 0x84 RW control, [7:0] only, reads zero-extended, drives `ctrl_out`
  - any other address: reads 32'hffffffff, writes ignored
- Writes to RO/unmapped addresses are dropped silently, never produce a completion, but still count in the write counter.
- Read data for counters reflects count before the current request.
- Counters are 32-bit, wrap 0xffffffff -> 0.
- Response buffer: one registered entry. `req_ready = !resp_valid || resp_ready`, combinational from registered state and `resp_ready` only (no path from `req_valid`).
- Accepted read loads buffer; accepted write leaves buffer empty (or drains it if `resp_ready`).

## Timing
- Reset values: `req_ready` 1 (derived), `resp_valid` 0, `resp_data` 0, `ctrl_out` 0, counters 0, scratch all-ones.
- Read latency: completion valid on the cycle after acceptance edge.
- Write effect: register updated at acceptance edge; a read accepted next cycle returns the new value.
- Stall: while `resp_valid && !resp_ready`, `resp_data` held bit-stable, `req_ready` 0, no request consumed.
- Back-to-back: with `resp_ready` held 1, one request per cycle sustained, completions in request order.
- Simultaneous completion handoff and new read acceptance: buffer reloads same edge, `resp_valid` stays 1.
- Reset assertion mid-transaction: pending completion discarded, `resp_valid` 0 immediately (async); registers return to reset values.
- Reset deassertion is synchronised externally; block first accepts on the first rising edge with `reset_n` high.

## Configuration
- `FEJKON_CSR_STATS_EN` defined: counters at 0x08/0x0C implemented as above.
- Undefined: no counter flops; 0x08/0x0C read 32'hffffffff like unmapped addresses; writes ignored.

## Test plan
- Reset, read 0x00 then 0x04 with requester/tag 24'h010203 -> completions [63:32]=02010de5 then deadbeef, [23:0]=010203, [28:24]=0 then 1.
- Write 0x80 = 32'h12345678, read 0x80 next cycle -> 12345678, [28:24]=5'h00 (address[6:2]); read 0x84 after write 0x1ff -> 0x000000ff, `ctrl_out`=8'hff.
- Read 0x100 and write 0x00 = 0 then read 0x00 -> ffffffff then 02010de5 (RO write dropped).
- Hold `resp_ready` 0 for 5 cycles with reads queued -> `req_ready` 0, `resp_data` stable, no loss; release -> remaining reads complete in order, one per cycle.
- With stats: 3 writes, 2 reads, then read 0x08 and 0x0C -> 3 and 3 (0x0C excludes itself: 2 prior reads + 0x08 read); without macro -> both ffffffff.
- Assert `reset_n` low while a completion is stalled -> `resp_valid` 0 same cycle, scratch ffffffff, `ctrl_out` 0 after release.
